irq_sequencer: RTL

IRQ_SEQUENCER -- requirements
Module: irq_sequencer

---
 rtl/irq_sequencer_pkg.sv | 15 +
 rtl/irq_sequencer_prio_enc.sv | 20 ++
 rtl/irq_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/irq_sequencer_pkg.sv
// Shared definitions for the interrupt/exception-entry sequencer.
package irq_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTRY = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int NUM_IRQ_DEF   = 4;
  localparam int ENTRY_LEN_DEF = 3;
  localparam int EXC_NUM_W     = 2;

endpackage

// File: rtl/irq_sequencer_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module irq_prio_enc
  import irq_sequencer_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF
) (
  input  logic [NUM_IRQ-1:0]   irq,
  output logic                 any,
  output logic [EXC_NUM_W-1:0] index
);

  always_comb begin
    any   = |irq;
    index = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq[i]) index = EXC_NUM_W'(i);
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Run/halt/wait control and exception-entry sequencing for a small CPU core.
//   state    | meaning
//   ST_RUN   | fetch/execute allowed, entry decisions taken on inst_done
//   ST_ENTRY | exception entry, ENTRY_LEN cycles, inst_done ignored
//   ST_WAIT  | stalled until any irq line rises
//   ST_HALT  | stopped, leaves only through rst
module irq_sequencer
  import irq_sequencer_pkg::*;
#(
  parameter int NUM_IRQ   = NUM_IRQ_DEF,
  parameter int ENTRY_LEN = ENTRY_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_done,
  input  logic                 halt,
  input  logic                 _wait,
  input  logic                 ei,
  input  logic                 di,
  input  logic                 rti,
  input  logic                 _int,
  input  logic [NUM_IRQ-1:0]   irq,
  output logic                 cpu_run,
  output logic                 exc_triggered,
  output logic [1:0]           entry_phase,
  output logic                 exc_hw,
  output logic [EXC_NUM_W-1:0] exc_num,
  output logic [NUM_IRQ-1:0]   irq_ack,
  output logic                 ie,
  output logic                 halted
);

  localparam logic [1:0] PH_LAST = 2'(ENTRY_LEN - 1);

  state_e               state_q, state_d;
  logic                 ie_q, ie_d;
  logic                 saved_ie_q, saved_ie_d;
  logic [1:0]           phase_q, phase_d;
  logic                 exc_hw_q, exc_hw_d;
  logic [EXC_NUM_W-1:0] exc_num_q, exc_num_d;
  logic [NUM_IRQ-1:0]   irq_ack_q, irq_ack_d;

  logic                 irq_any;
  logic [EXC_NUM_W-1:0] irq_idx;
  logic                 take_sw, take_hw;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .irq   (irq),
    .any   (irq_any),
    .index (irq_idx)
  );

  always_comb begin
    state_d    = state_q;
    ie_d       = ie_q;
    saved_ie_d = saved_ie_q;
    phase_d    = phase_q;
    exc_hw_d   = exc_hw_q;
    exc_num_d  = exc_num_q;
    irq_ack_d  = '0;
    take_sw    = 1'b0;
    take_hw    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (inst_done) begin
          // ie_q is the pre-update value, giving ei/di a one-instruction shadow
          take_sw = _int;
          take_hw = !_int && ie_q && irq_any;
          if (rti)     ie_d = saved_ie_q;
          else if (di) ie_d = 1'b0;
          else if (ei) ie_d = 1'b1;
          if (!take_sw && !take_hw) begin
            if (halt)       state_d = ST_HALT;
            else if (_wait) state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (irq_any) begin
          if (ie_q) take_hw = 1'b1;
          else      state_d = ST_RUN;
        end
      end
      ST_ENTRY: begin
        if (phase_q == PH_LAST) begin
          state_d = ST_RUN;
          phase_d = 2'd0;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      ST_HALT: ;
      default: state_d = ST_RUN;
    endcase

    // Entry overrides any ie update from the retiring instruction
    if (take_sw || take_hw) begin
      state_d    = ST_ENTRY;
      phase_d    = 2'd0;
      saved_ie_d = ie_q;
      ie_d       = 1'b0;
      exc_hw_d   = take_hw;
      exc_num_d  = take_hw ? irq_idx : '0;
      if (take_hw) irq_ack_d = {{(NUM_IRQ-1){1'b0}}, 1'b1} << irq_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      ie_q       <= 1'b0;
      saved_ie_q <= 1'b0;
      phase_q    <= 2'd0;
      exc_hw_q   <= 1'b0;
      exc_num_q  <= '0;
      irq_ack_q  <= '0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      saved_ie_q <= saved_ie_d;
      phase_q    <= phase_d;
      exc_hw_q   <= exc_hw_d;
      exc_num_q  <= exc_num_d;
      irq_ack_q  <= irq_ack_d;
    end
  end

  assign cpu_run       = (state_q == ST_RUN);
  assign exc_triggered = (state_q == ST_ENTRY);
  assign halted        = (state_q == ST_HALT);
  assign entry_phase   = phase_q;
  assign exc_hw        = exc_hw_q;
  assign exc_num       = exc_num_q;
  assign irq_ack       = irq_ack_q;
  assign ie            = ie_q;

endmodule
